// File: rtl/uart_rx_cfg_if.sv
// Receiver-side signal bundle: serial line in, recovered word and status out.
// The receiver uses the slave modport; the line driver and host use master.
interface uart_rx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic                 data_in;
  logic [DATA_BITS-1:0] data_out;
  logic                 done;
  logic                 parity_err;
  logic                 frame_err;
  logic                 busy;

  modport master (
    output data_in,
    input  data_out, done, parity_err, frame_err, busy
  );

  modport slave (
    input  data_in,
    output data_out, done, parity_err, frame_err, busy
  );
endinterface

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-flop synchroniser, start-glitch rejection,
// mid-bit sampling, parity/framing flags, and a one-cycle done pulse.
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  uart_rx_cfg_if.slave rx
);

  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = 4;

  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);
  localparam logic             ODD_BIT   = (PARITY_ODD != 0);
  localparam logic             HAS_PAR   = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  logic                 sync1_q, sync2_q;
  logic                 rxs;
  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shadow_q, shadow_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 armed_q, armed_d;
  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic                 done_q, done_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 mid_bit;
  logic                 ferr_now;

  // Synchroniser resets to the idle-high line level so reset never looks like a start.
  // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx.data_in;
      sync2_q <= sync1_q;
    end
  end

  assign rxs = sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      armed_q      <= 1'b1;
      data_out_q   <= '0;
      done_q       <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      armed_q      <= armed_d;
      data_out_q   <= data_out_d;
      done_q       <= done_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign mid_bit = (cnt_q == CNT_FULL);

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d      = state_q;
    cnt_d        = cnt_q + CNT_W'(1);
    idx_d        = idx_q;
    shadow_d     = shadow_q;
    perr_d       = perr_q;
    ferr_d       = ferr_q;
    armed_d      = armed_q;
    data_out_d   = data_out_q;
    done_d       = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    ferr_now     = ferr_q | ~rxs;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (rxs) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = S_START;
        end
      end

      // Re-check half a bit later; a line back high by then was only a glitch.
      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (rxs) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            idx_d   = '0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
          end
        end
      end

      S_DATA: begin
        if (mid_bit) begin
          cnt_d    = '0;
          shadow_d = {rxs, shadow_q[DATA_BITS-1:1]};
          if (idx_q == LAST_DATA) begin
            idx_d   = '0;
            state_d = HAS_PAR ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      S_PARITY: begin
        if (mid_bit) begin
          cnt_d   = '0;
          perr_d  = (^shadow_q) ^ rxs ^ ODD_BIT;
          idx_d   = '0;
          state_d = S_STOP;
        end
      end

      // Results are published on the last stop sample so data_out and done rise together.
      S_STOP: begin
        if (mid_bit) begin
          cnt_d  = '0;
          ferr_d = ferr_now;
          if (idx_q == LAST_STOP) begin
            state_d      = S_DONE;
            done_d       = 1'b1;
            data_out_d   = shadow_q;
            parity_err_d = perr_q;
            frame_err_d  = ferr_now;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      // A framing error disarms start detection until the line has been seen high.
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
        if (ferr_q) begin
          armed_d = 1'b0;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign rx.data_out   = data_out_q;
  assign rx.done       = done_q;
  assign rx.parity_err = parity_err_q;
  assign rx.frame_err  = frame_err_q;
  assign rx.busy       = (state_q != S_IDLE);

endmodule
